ahb_slave_arbiter: RTL and testbench
====================================

# ahb_slave_arbiter

Per-slave-port arbiter for the generated AHB interconnect. It sits in front of one slave port and decides which of CHANNEL_NUM masters owns the address phase. It produces the one-hot address-phase and data-phase selects that steer the slave-side request mux. It also generates per-master stall indications.

## Interface
- CHANNEL_NUM, 3, number of masters that can reach this slave; 2..16.
- HCLK  in  1  clock; all state updates on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- req  in  CHANNEL_NUM  bit i: master i drives a NONSEQ/SEQ transfer decoded to this slave.
- last  in  CHANNEL_NUM  bit i: master i's current transfer is the final beat of its burst (1 for SINGLE).
- lock  in  CHANNEL_NUM  bit i: master i's HMASTLOCK.
- HREADY  in  1  HREADYOUT of the slave.
- addr_sel  out  CHANNEL_NUM  one-hot or zero; current address-phase owner (registered).
- data_sel  out  CHANNEL_NUM  one-hot or zero; master whose transfer is in data phase (registered).
- wait_out  out  CHANNEL_NUM  bit i high: master i must see HREADY low (combinational).
- busy  out  1  high when addr_sel or data_sel is non-zero.

## Operation
- States: IDLE (addr_sel = 0), OWNED (addr_sel = onehot(owner)), LOCKED (OWNED with lock[owner] = 1).
- State, addr_sel and data_sel advance only on HREADY = 1 cycles. When HREADY = 0, all state holds.
- A transfer is accepted in a cycle where addr_sel[i] & req[i] & HREADY.
- Arbitration happens on an HREADY = 1 cycle when any of these holds:
  - the state is IDLE;
  - the owner has an accepted transfer with last = 1 and lock = 0;
  - the owner has req = 0 and lock = 0.
- Arbitration result:
  - Winner among req bits → OWNED with addr_sel = onehot(winner).
  - No req → IDLE.
- Owner keeps the grant when:
  - it is mid-burst (accepted with last = 0);
  - lock[owner] = 1, regardless of req or last (LOCKED). LOCKED exits only when an accepted transfer has lock = 0, or when req = 0 and lock = 0.
- data_sel ← addr_sel & req on every HREADY = 1 cycle. A zero result means no data phase.
- wait_out[i] = req[i] & ~(addr_sel[i] & HREADY). A non-owner requester is stalled until granted.
- busy = |addr_sel | |data_sel.
- Reset (HRESET = 1 at an edge): state IDLE, addr_sel = 0, data_sel = 0, round-robin pointer = 0. busy is low the following cycle. Any transfer in flight is dropped; no partial grant survives.
- addr_sel and data_sel are never multi-hot.

## Timing
- Grant latency from IDLE: req[k] high at cycle t with HREADY = 1 → addr_sel = onehot(k) at t+1. The transfer is accepted at t+1 if HREADY = 1, and data_sel = onehot(k) at t+2.
- wait_out[k] is high at t and low at t+1, provided HREADY = 1.
- Handover: the owner's last beat is accepted at t → the new addr_sel is valid at t+1. The old owner's data_sel is valid at t+1 in parallel, giving back-to-back pipelining with no dead cycle.
- HREADY low for N cycles extends every phase by exactly N cycles. The outputs wait_out and busy track this combinationally.
- Simultaneous requests in the same cycle are resolved by one winner per arbitration; losers keep wait_out high.

## Configuration
- AHB_ARB_ROUND_ROBIN_EN defined:
  - Round-robin selection. The search starts at index (previous owner + 1) mod CHANNEL_NUM. The pointer updates on every grant. The previous owner has lowest priority.
- Not defined:
  - Fixed priority; the lowest index wins. The pointer register is removed.

## Test plan
- Single master: reset, then req[1] = 1, last = 1, HREADY = 1 at t0 → addr_sel = 3'b010 at t0+1, data_sel = 3'b010 at t0+2. After req drops, busy = 0 at t0+3.
- Contention: req = 3'b111, each master issues a SINGLE. With AHB_ARB_ROUND_ROBIN_EN the grant order is 0, 1, 2, 0. Without it, order is 0, 0, 0 while req[0] stays high, and wait_out[2:1] stays high.
- Burst hold: master 0 runs an INCR4 (last = 1 only on beat 4) while req[2] is high → addr_sel stays 3'b001 for 4 accepted beats, then 3'b100 on the next cycle.
- Lock: lock[1] = 1 with req[1] toggling low for 2 cycles → addr_sel stays 3'b010 throughout. It is released after the first accepted transfer with lock = 0.
- Wait states: HREADY low for 3 cycles mid-burst → addr_sel, data_sel and the pointer are frozen, and wait_out = req for the whole stall.
- Reset mid-burst: HRESET = 1 during beat 2 of a burst → next cycle addr_sel = 0, data_sel = 0, busy = 0. With req still high, the grant reappears one cycle after HRESET drops.

Source files
------------

// File: rtl/ahb_slave_arbiter_if.sv
// Request/grant bundle between the masters routed to one AHB slave port and
// that port's arbiter.
//
// Handshake: req[i] is master i's "valid" and (addr_sel[i] & HREADY) is its
// "ready". A transfer is accepted only in a cycle where both are high. While
// valid is high without ready, the master must hold its request stable, and
// wait_out[i] tells it to stall.
interface ahb_slave_arbiter_if #(
    parameter int CHANNEL_NUM = 3
);
    logic [CHANNEL_NUM-1:0] req;
    logic [CHANNEL_NUM-1:0] last;
    logic [CHANNEL_NUM-1:0] lock;
    logic                   HREADY;
    logic [CHANNEL_NUM-1:0] addr_sel;
    logic [CHANNEL_NUM-1:0] data_sel;
    logic [CHANNEL_NUM-1:0] wait_out;
    logic                   busy;

    // Request side: the masters plus the slave's HREADYOUT.
    modport master (
        output req, last, lock, HREADY,
        input  addr_sel, data_sel, wait_out, busy
    );

    // Arbiter side.
    modport slave (
        input  req, last, lock, HREADY,
        output addr_sel, data_sel, wait_out, busy
    );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// Per-slave-port AHB arbiter. It picks which master owns the address phase,
// tracks which master is in the data phase, and stalls the masters that are
// requesting but not granted.
// Optional feature macro: AHB_ARB_ROUND_ROBIN_EN. When it is defined, the
// arbiter uses round-robin selection with a pointer register. When it is not
// defined, the lowest requesting index wins.
// o_dbg_state exposes the FSM state: 0 = IDLE, 1 = OWNED, 2 = LOCKED.
module ahb_slave_arbiter #(
    parameter int CHANNEL_NUM = 3
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_slave_arbiter_if.slave io_bus,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CHANNEL_NUM-1:0] r_addr_sel;
    logic [CHANNEL_NUM-1:0] w_addr_sel_nxt;
    logic [CHANNEL_NUM-1:0] r_data_sel;
    logic [CHANNEL_NUM-1:0] w_data_sel_nxt;

    logic                   w_own_req;
    logic                   w_own_last;
    logic                   w_own_lock;
    logic                   w_arbitrate;
    logic [CHANNEL_NUM-1:0] w_win_onehot;
    logic                   w_win_any;
    logic                   w_win_lock;

    // Owner attributes. addr_sel is at most one-hot, so a masked OR-reduce
    // selects the owner's bit.
    assign w_own_req  = |(r_addr_sel & io_bus.req);
    assign w_own_last = |(r_addr_sel & io_bus.last);
    assign w_own_lock = |(r_addr_sel & io_bus.lock);
    assign w_win_lock = |(w_win_onehot & io_bus.lock);

`ifdef AHB_ARB_ROUND_ROBIN_EN
    localparam int PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    // r_ptr holds the first index to search. It is written as
    // (last winner + 1), so the previous owner has the lowest priority.
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W-1:0] w_win_idx;
    logic [PTR_W-1:0] w_cand;

    // Computes (base + step) mod CHANNEL_NUM. Both operands are already
    // below CHANNEL_NUM, so a single conditional subtract is enough.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int step);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + (PTR_W+1)'(step);
        if (sum >= (PTR_W+1)'(CHANNEL_NUM)) begin
            sum = sum - (PTR_W+1)'(CHANNEL_NUM);
        end
        return sum[PTR_W-1:0];
    endfunction

    // Round-robin search: the first requester at or after r_ptr, with wrap-around.
    always_comb begin
        w_win_onehot = '0;
        w_win_idx    = '0;
        w_win_any    = 1'b0;
        w_cand       = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            w_cand = wrap_add(r_ptr, k);
            if (!w_win_any && io_bus.req[w_cand]) begin
                w_win_onehot[w_cand] = 1'b1;
                w_win_idx            = w_cand;
                w_win_any            = 1'b1;
            end
        end
    end

    // Pointer register. It only moves on a grant and holds through wait states.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    // Fixed-priority search: the lowest requesting index wins.
    always_comb begin
        w_win_onehot = '0;
        w_win_any    = 1'b0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            if (!w_win_any && io_bus.req[k]) begin
                w_win_onehot[k] = 1'b1;
                w_win_any       = 1'b1;
            end
        end
    end
`endif

    // State register: the FSM state, the grant, and the data-phase owner.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_addr_sel <= '0;
            r_data_sel <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr_sel <= w_addr_sel_nxt;
            r_data_sel <= w_data_sel_nxt;
        end
    end

    // Next state: hold on a lock or mid-burst, re-arbitrate otherwise. Nothing moves while HREADY is low.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_sel_nxt = r_addr_sel;
        w_data_sel_nxt = r_data_sel;
        w_arbitrate    = 1'b0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
        w_ptr_nxt      = r_ptr;
`endif
        if (io_bus.HREADY) begin
            // The owner's accepted transfer, if any, moves into the data phase.
            w_data_sel_nxt = r_addr_sel & io_bus.req;
            if (r_state == ST_IDLE) begin
                w_arbitrate = 1'b1;
            end else if (w_own_lock) begin
                // A locked owner keeps the bus whatever its req or last are.
                w_state_nxt = ST_LOCKED;
            end else if (w_own_req && !w_own_last) begin
                // The owner is mid-burst.
                w_state_nxt = ST_OWNED;
            end else begin
                // The final beat was accepted, or the owner went idle without a lock.
                w_arbitrate = 1'b1;
            end

            if (w_arbitrate) begin
                if (w_win_any) begin
                    w_addr_sel_nxt = w_win_onehot;
                    w_state_nxt    = w_win_lock ? ST_LOCKED : ST_OWNED;
`ifdef AHB_ARB_ROUND_ROBIN_EN
                    w_ptr_nxt      = wrap_add(w_win_idx, 1);
`endif
                end else begin
                    w_addr_sel_nxt = '0;
                    w_state_nxt    = ST_IDLE;
                end
            end
        end
    end

    // Outputs: the registered selects, plus the stall and busy flags, which depend combinationally on req and HREADY.
    always_comb begin
        io_bus.addr_sel = r_addr_sel;
        io_bus.data_sel = r_data_sel;
        io_bus.wait_out = io_bus.req & ~(r_addr_sel & {CHANNEL_NUM{io_bus.HREADY}});
        io_bus.busy     = (|r_addr_sel) | (|r_data_sel);
        o_dbg_state     = r_state;
    end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter with CHANNEL_NUM = 3. It drives inputs
// at posedge + 1 and samples outputs before the next edge. Expectations that
// depend on the arbitration policy follow AHB_ARB_ROUND_ROBIN_EN.
module tb_ahb_slave_arbiter;

    localparam int N = 3;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_vec;
    int         n_err;

    // Policy-dependent expectations.
    logic [2:0] cont_addr [4];
    logic [2:0] cont_wait [4];
    logic [2:0] burst_next;
    logic [2:0] stall_next;

    ahb_slave_arbiter_if #(.CHANNEL_NUM(N)) bus_if ();

    ahb_slave_arbiter #(.CHANNEL_NUM(N)) dut (
        .HCLK        (clk),
        .HRESET      (rst),
        .io_bus      (bus_if),
        .o_dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] last,
                         input logic [2:0] lock, input logic hready);
        bus_if.req    = req;
        bus_if.last   = last;
        bus_if.lock   = lock;
        bus_if.HREADY = hready;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'b000, 3'b000, 3'b000, 1'b1);
        tick();
        rst = 1'b0;
    endtask

    // Comparison point.
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
        cont_addr = '{3'b001, 3'b010, 3'b100, 3'b001};
        cont_wait = '{3'b110, 3'b101, 3'b011, 3'b110};
        burst_next = 3'b100;
        stall_next = 3'b010;
`else
        cont_addr = '{3'b001, 3'b001, 3'b001, 3'b001};
        cont_wait = '{3'b110, 3'b110, 3'b110, 3'b110};
        burst_next = 3'b001;
        stall_next = 3'b001;
`endif

        // Reset state.
        rst = 1'b1;
        drive(3'b000, 3'b000, 3'b000, 1'b1);
        tick();
        tick();
        chk("rst addr_sel", bus_if.addr_sel, 3'b000);
        chk("rst data_sel", bus_if.data_sel, 3'b000);
        chk("rst busy", bus_if.busy, 1'b0);
        chk("rst state", dbg_state, 2'd0);
        chk("rst wait_out", bus_if.wait_out, 3'b000);

        // Single master 1, SINGLE transfer.
        rst = 1'b0;
        drive(3'b010, 3'b010, 3'b000, 1'b1);
        chk("single wait t0", bus_if.wait_out, 3'b010);
        chk("single busy t0", bus_if.busy, 1'b0);
        tick();
        chk("single addr t1", bus_if.addr_sel, 3'b010);
        chk("single data t1", bus_if.data_sel, 3'b000);
        chk("single wait t1", bus_if.wait_out, 3'b000);
        chk("single busy t1", bus_if.busy, 1'b1);
        tick();
        chk("single data t2", bus_if.data_sel, 3'b010);
        chk("single addr t2", bus_if.addr_sel, 3'b010);
        drive(3'b000, 3'b000, 3'b000, 1'b1);
        tick();
        chk("single addr t3", bus_if.addr_sel, 3'b000);
        chk("single data t3", bus_if.data_sel, 3'b000);
        chk("single busy t3", bus_if.busy, 1'b0);
        chk("single state t3", dbg_state, 2'd0);

        // Contention: all three masters issue SINGLEs continuously.
        do_reset();
        drive(3'b111, 3'b111, 3'b000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("contend addr %0d", i), bus_if.addr_sel, cont_addr[i]);
            chk($sformatf("contend wait %0d", i), bus_if.wait_out, cont_wait[i]);
        end
        chk("contend data 3", bus_if.data_sel, cont_addr[2]);

        // Burst hold: master 0 runs INCR4 while master 2 waits.
        do_reset();
        drive(3'b101, 3'b000, 3'b000, 1'b1);
        tick();
        chk("burst grant", bus_if.addr_sel, 3'b001);
        chk("burst wait", bus_if.wait_out, 3'b100);
        tick();
        chk("burst beat1 addr", bus_if.addr_sel, 3'b001);
        chk("burst beat1 data", bus_if.data_sel, 3'b001);
        tick();
        chk("burst beat2 addr", bus_if.addr_sel, 3'b001);
        tick();
        chk("burst beat3 addr", bus_if.addr_sel, 3'b001);
        drive(3'b101, 3'b001, 3'b000, 1'b1);
        tick();
        chk("burst handover addr", bus_if.addr_sel, burst_next);
        chk("burst handover data", bus_if.data_sel, 3'b001);

        // Wait states: HREADY low for 3 cycles mid-burst.
        do_reset();
        drive(3'b001, 3'b000, 3'b000, 1'b1);
        tick();
        tick();
        drive(3'b011, 3'b000, 3'b000, 1'b0);
        chk("stall wait entry", bus_if.wait_out, 3'b011);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall addr %0d", i), bus_if.addr_sel, 3'b001);
            chk($sformatf("stall data %0d", i), bus_if.data_sel, 3'b001);
            chk($sformatf("stall wait %0d", i), bus_if.wait_out, 3'b011);
        end
        drive(3'b011, 3'b001, 3'b000, 1'b1);
        chk("stall wait resume", bus_if.wait_out, 3'b010);
        tick();
        chk("stall next addr", bus_if.addr_sel, stall_next);
        chk("stall next data", bus_if.data_sel, 3'b001);

        // Lock: master 1 holds the bus through a request gap.
        do_reset();
        drive(3'b010, 3'b010, 3'b010, 1'b1);
        tick();
        chk("lock grant", bus_if.addr_sel, 3'b010);
        chk("lock state", dbg_state, 2'd2);
        drive(3'b001, 3'b000, 3'b010, 1'b1);
        tick();
        chk("lock gap1 addr", bus_if.addr_sel, 3'b010);
        chk("lock gap1 wait", bus_if.wait_out, 3'b001);
        tick();
        chk("lock gap2 addr", bus_if.addr_sel, 3'b010);
        chk("lock gap2 data", bus_if.data_sel, 3'b000);
        drive(3'b011, 3'b010, 3'b010, 1'b1);
        tick();
        chk("lock held addr", bus_if.addr_sel, 3'b010);
        drive(3'b011, 3'b010, 3'b000, 1'b1);
        tick();
        chk("lock release addr", bus_if.addr_sel, 3'b001);
        chk("lock release data", bus_if.data_sel, 3'b010);
        chk("lock release state", dbg_state, 2'd1);

        // Reset mid-burst.
        do_reset();
        drive(3'b001, 3'b000, 3'b000, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst addr", bus_if.addr_sel, 3'b000);
        chk("midrst data", bus_if.data_sel, 3'b000);
        chk("midrst busy", bus_if.busy, 1'b0);
        chk("midrst wait", bus_if.wait_out, 3'b001);
        rst = 1'b0;
        tick();
        chk("midrst regrant", bus_if.addr_sel, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
